dom_share_encoder: RTL and testbench
====================================

DOM_SHARE_ENCODER -- requirements
Module: dom_share_encoder

Interface
REQ-001 Parameter WIDTH, default 8: plaintext and share width; legal range 1..16.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 seed_valid  in  1  seed load strobe.
REQ-005 seed  in  32  PRNG seed value.
REQ-006 in_valid  in  1  plaintext available.
REQ-007 in_data  in  WIDTH  unmasked plaintext.
REQ-008 in_ready  out  1  encoder accepts plaintext this cycle.
REQ-009 out_valid  out  1  share pair and fresh randomness valid.
REQ-010 out_share0  out  WIDTH  share 0 = plaintext XOR mask.
REQ-011 out_share1  out  WIDTH  share 1 = mask.
REQ-012 out_r  out  WIDTH  fresh randomness for the downstream first-order DOM AND refresh input.
REQ-013 out_ready  in  1  consumer takes the output.
REQ-014 seeded  out  1  PRNG holds a valid seed.

Function
REQ-015 FSM states: UNSEEDED (reset state), RUN.
- UNSEEDED -> RUN on seed_valid.
- RUN -> RUN on seed_valid (reseed).
- No other transitions.
REQ-016 PRNG: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shifting toward bit 0.
REQ-017 Seed load: lfsr <= seed; seed of 32'h0 loads 32'h0000_0001 instead (all-zero lock-up forbidden).
REQ-018 in_ready = (state==RUN) && !seed_valid && (!out_valid || out_ready).
REQ-019 Accept (in_valid && in_ready), from current lfsr value L:
- m = L[WIDTH-1:0], r = L[2*WIDTH-1:WIDTH].
- Registered: out_share0 <= in_data ^ m; out_share1 <= m; out_r <= r; out_valid <= 1.
REQ-020 Latency: outputs valid exactly one cycle after accept; throughput one word per cycle while out_ready=1.
REQ-021 On accept, lfsr advances 2*WIDTH single LFSR steps in that cycle; no mask or r bit is ever reused.
REQ-022 Without accept and without seed load, lfsr holds its value.
REQ-023 Output stage: out_valid && !out_ready holds all outputs stable; out_valid clears on out_ready when no new accept happens in the same cycle.
REQ-024 Simultaneous seed_valid and in_valid: seed wins, nothing accepted, pending output unaffected.
REQ-025 In UNSEEDED, in_ready = 0 regardless of in_valid or out_ready.
REQ-026 out_share0 ^ out_share1 == accepted in_data for every valid output; the combinational path from in_data to either share contains no unmasked XOR (share0 registered directly).
REQ-027 seeded = (state==RUN).

Reset
REQ-028 Assertion of rst_n=0 at any time, including mid-transfer, forces: state UNSEEDED, lfsr 32'h0000_0001, out_valid 0, out_share0/out_share1/out_r all 0, seeded 0, in_ready 0.
REQ-029 A word pending at reset is discarded; no output appears after release until a new seed and accept.

Structure
REQ-030 Shared package dom_pkg holds: LFSR_POLY constant, LFSR_W=32, FSM state typedef.
REQ-031 One sub-module, dom_lfsr_step: combinational, state and step count in, advanced state out; used with count 2*WIDTH.
REQ-032 Elaboration check: WIDTH outside 1..16 is an error.

Verification
REQ-033 Seed 32'h0000_0001, in_data 8'hA5 accepted -> next cycle out_share1=8'h01, out_share0=8'hA4, out_r=8'h00, out_valid=1.
REQ-034 Seed 32'h0 -> seeded=1 and the first output is identical to the REQ-033 result for the same in_data.
REQ-035 No seed, in_valid=1 for 10 cycles -> in_ready=0 and out_valid=0 throughout.
REQ-036 Seeded, out_ready=0 for 3 cycles after an accept -> outputs constant, in_ready=0; out_ready=1 -> transfer, then next accept uses an advanced mask.
REQ-037 Streaming 256 words with random out_ready -> every word recovered as share0^share1, in order, no duplicate (mask, r) pair from consecutive lfsr states.
REQ-038 rst_n pulled low while out_valid=1 and out_ready=0 -> all outputs 0 immediately; after release, in_ready=0 until seed_valid.

Source files
------------

// File: rtl/dom_pkg.sv
// Shared definitions for the DOM share encoder: PRNG constants and FSM states.
package dom_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 32'h0000_0001;

  typedef enum logic {
    ST_UNSEEDED,
    ST_RUN
  } dom_state_e;

endpackage

// File: rtl/dom_lfsr_step.sv
// Combinational multi-step advance of the 32-bit Galois LFSR (shifts toward bit 0).
module dom_lfsr_step
  import dom_pkg::*;
#(
  parameter int unsigned STEPS = 16
) (
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state
);

  logic [LFSR_W-1:0] acc;

  // Unrolled chain of STEPS single Galois steps.
  always_comb begin
    acc = state;
    for (int unsigned i = 0; i < STEPS; i++) begin
      acc = {1'b0, acc[LFSR_W-1:1]} ^ (acc[0] ? LFSR_POLY : '0);
    end
    next_state = acc;
  end

endmodule

// File: rtl/dom_share_encoder.sv
// Splits plaintext into two Boolean shares and emits fresh randomness for a DOM AND.
module dom_share_encoder
  import dom_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [31:0]      seed,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_share0,
  output logic [WIDTH-1:0] out_share1,
  output logic [WIDTH-1:0] out_r,
  input  logic             out_ready,
  output logic             seeded
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_width_check
    $error("dom_share_encoder: WIDTH must be in 1..16");
  end

  dom_state_e        state, state_next;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [WIDTH-1:0]  mask;
  logic [WIDTH-1:0]  rnd;
  logic              accept;

  assign mask   = lfsr[WIDTH-1:0];
  assign rnd    = lfsr[2*WIDTH-1:WIDTH];
  assign seeded = (state == ST_RUN);

  // Seed load has priority: in_ready drops whenever seed_valid is high.
  assign in_ready = (state == ST_RUN) && !seed_valid && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  dom_lfsr_step #(
    .STEPS(2 * WIDTH)
  ) u_step (
    .state     (lfsr),
    .next_state(lfsr_adv)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_UNSEEDED;
    else        state <= state_next;
  end

  // Next state: any seed load lands in (or stays in) RUN.
  always_comb begin
    state_next = state;
    if (seed_valid) state_next = ST_RUN;
  end

  // PRNG: load seed (never all-zero) or consume 2*WIDTH bits per accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_RESET;
    end else if (seed_valid) begin
      lfsr <= (seed == '0) ? LFSR_RESET : seed;
    end else if (accept) begin
      lfsr <= lfsr_adv;
    end
  end

  // Output register: share0 is formed and registered in one step so no unmasked value persists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_share0 <= '0;
      out_share1 <= '0;
      out_r      <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_share0 <= in_data ^ mask;
      out_share1 <= mask;
      out_r      <= rnd;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dom_share_encoder.sv
// Randomised self-checking bench for dom_share_encoder against a behavioural model.
module tb_dom_share_encoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         seed_valid;
  logic [31:0]  seed;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_share0;
  logic [W-1:0] out_share1;
  logic [W-1:0] out_r;
  logic         out_ready;
  logic         seeded;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dom_share_encoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_valid(seed_valid),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_share0(out_share0),
    .out_share1(out_share1),
    .out_r     (out_r),
    .out_ready (out_ready),
    .seeded    (seeded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One Galois step of x^32+x^22+x^2+x+1, shifting toward bit 0.
  function automatic logic [31:0] lfsr_step1(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // ---------------- behavioural model ----------------
  logic         m_run;
  logic [31:0]  m_l;
  logic         m_ov;
  logic [W-1:0] m_s0, m_s1, m_r;
  int           m_acc_cnt = 0;
  logic [W-1:0] m_q[$];

  function automatic logic exp_in_ready();
    return m_run && !seed_valid && (!m_ov || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_l = 32'h1; m_ov = 1'b0;
      m_s0 = '0; m_s1 = '0; m_r = '0;
      m_q.delete();
    end else begin
      if (exp_in_ready() && in_valid) begin
        m_s1 = m_l[W-1:0];
        m_r  = m_l[2*W-1:W];
        m_s0 = in_data ^ m_s1;
        m_ov = 1'b1;
        m_q.push_back(in_data);
        m_acc_cnt++;
        for (int k = 0; k < 2*W; k++) m_l = lfsr_step1(m_l);
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (seed_valid) begin
        m_run = 1'b1;
        m_l   = (seed == 32'h0) ? 32'h1 : seed;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    check("in_ready", in_ready, exp_in_ready());
    check("out_valid", out_valid, m_ov);
    check("seeded", seeded, m_run);
    check("out_share0", out_share0, m_s0);
    check("out_share1", out_share1, m_s1);
    check("out_r", out_r, m_r);
    if (rst_n && out_valid && out_ready) begin
      if (m_q.size() == 0) check("transfer_queue_empty", 32'h1, 32'h0);
      else check("recovered", out_share0 ^ out_share1, m_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    seed_valid = 1'b0; seed = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_valid = 1'b1; seed = s;
    tick();
    seed_valid = 1'b0;
  endtask

  int start_cnt;
  int cyc;

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    check("model_step_a", lfsr_step1(32'h0000_0001), 32'h8020_0003);
    check("model_step_b", lfsr_step1(32'h8020_0003), 32'hC030_0002);

    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_seeded", seeded, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_share0", out_share0, 8'h00);
    tick();
    rst_n = 1'b1;

    // No seed yet: requests must be ignored.
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("unseeded_in_ready", in_ready, 1'b0);
      check("unseeded_out_valid", out_valid, 1'b0);
      tick();
    end
    idle_inputs();

    // Seed 1, accept A5.
    load_seed(32'h0000_0001);
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("vec1_valid", out_valid, 1'b1);
    check("vec1_share1", out_share1, 8'h01);
    check("vec1_share0", out_share0, 8'hA4);
    check("vec1_r", out_r, 8'h00);
    tick();

    // Seed 0 is replaced by 1: identical first output.
    load_seed(32'h0);
    @(negedge clk);
    check("seed0_seeded", seeded, 1'b1);
    tick();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("seed0_share1", out_share1, 8'h01);
    check("seed0_share0", out_share0, 8'hA4);
    check("seed0_r", out_r, 8'h00);
    tick();

    // Backpressure: hold for 3 cycles, then release.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();

    // Seed and data together: seed wins.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    seed_valid = 1'b1; seed = 32'hDEAD_BEEF;
    @(negedge clk);
    check("seed_vs_data_in_ready", in_ready, 1'b0);
    tick();
    seed_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick();

    // Random streaming of at least 256 words.
    start_cnt = m_acc_cnt;
    cyc = 0;
    while ((m_acc_cnt - start_cnt) < 256 && cyc < 4000) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(2) != 0);
      seed_valid = ($urandom_range(63) == 0);
      seed      = $urandom;
      tick();
      cyc++;
    end
    check("stream_word_count", ((m_acc_cnt - start_cnt) >= 256) ? 32'h1 : 32'h0, 32'h1);
    idle_inputs();
    out_ready = 1'b1;
    tick(); tick();

    // Reset while a word is stalled.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_valid", out_valid, 1'b0);
    check("reset_async_share0", out_share0, 8'h00);
    check("reset_async_share1", out_share1, 8'h00);
    check("reset_async_r", out_r, 8'h00);
    check("reset_async_seeded", seeded, 1'b0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_in_ready", in_ready, 1'b0);
      check("post_reset_valid", out_valid, 1'b0);
      tick();
    end
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
